multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Main control FSM for the multicycle RV32I core. Sequences the shared datapath
//  (PC, IR, register file, single ALU, immediate extender, unified memory port)
//  for each instruction. Drives mux selects, write enables, alu_control and imm_src.
//  It also stalls on a memory-ready handshake. Supports lw, sw, R-type, I-type ALU,
//  beq/bne and jal.
// PARAMETERS
//  none. All encodings come from rvscc_ctrl_pkg.
// PORTS
//  clk          in   1  clock; one clock, all state on rising edge
//  rst          in   1  reset is asynchronous and active-high
//  opcode       in   7  instr[6:0], valid from DECODE onward (IR registered)
//  funct3       in   3  instr[14:12]
//  funct7_5     in   1  instr[30]
//  zero         in   1  ALU result == 0 (combinational, current cycle)
//  mem_ready    in   1  memory completes the current access this cycle
//  pc_write     out  1  PC register enable
//  adr_src      out  1  memory address: 0 PC, 1 result
//  mem_write    out  1  memory write strobe
//  ir_write     out  1  IR/OldPC enable
//  result_src   out  2  0 alu_out reg, 1 mem data reg, 2 ALU result
//  alu_src_a    out  2  0 PC, 1 OldPC, 2 rd1
//  alu_src_b    out  2  0 rd2, 1 imm_ext, 2 const 4
//  alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  imm_src      out  2  extender select: 0 I, 1 S, 2 B, 3 J
//  reg_write    out  1  register file write enable
//  illegal_instr out 1  one-cycle pulse in DECODE on an unsupported opcode
// BEHAVIOUR
//  - rst high: state = FETCH immediately. pc_write, ir_write, mem_write, reg_write
//    and illegal_instr are forced to 0 while rst is high. Reset mid-access aborts
//    the access with no write.
//  - Moore outputs from state, except pc_write = pc_update | (branch & (zero ^ funct3[0])).
//  - Unlisted selects are 0. alu_op is internal: ADD, SUB, or FUNCT (alu decoder).
//  - FETCH: adr_src=0, a=0, b=2, ADD, result_src=2. ir_write = pc_update = mem_ready.
//    Stays in FETCH while !mem_ready, then goes to DECODE.
//  - DECODE: a=1, b=1, ADD. imm_src = 2 for branch, 3 for jal, else 0.
//    Next state: 0000011 or 0100011 -> MEM_ADR; 0110011 -> EXEC_R;
//    0010011 -> EXEC_I; 1101111 -> JAL; 1100011 -> BRANCH;
//    any other opcode -> FETCH with illegal_instr=1.
//  - MEM_ADR: a=2, b=1, ADD. imm_src = 1 if opcode[5], else 0.
//    Goes to MEM_WRITE if opcode[5], else MEM_READ.
//  - MEM_READ: adr_src=1, result_src=0. Holds until mem_ready, then MEM_WB.
//  - MEM_WB: result_src=1, reg_write=1, then FETCH.
//  - MEM_WRITE: adr_src=1, result_src=0. mem_write held high until mem_ready, then FETCH.
//  - EXEC_R: a=2, b=0, FUNCT, then ALU_WB.
//  - EXEC_I: a=2, b=1, imm_src=0, FUNCT, then ALU_WB.
//  - ALU_WB: result_src=0, reg_write=1, then FETCH.
//  - JAL: a=1, b=2, ADD, result_src=0, pc_update=1, imm_src=3, then ALU_WB
//    (rd = OldPC+4).
//  - BRANCH: a=2, b=0, SUB, result_src=0, branch=1, imm_src=2, then FETCH.
//    funct3[0]=0 is beq, 1 is bne. Branch taken -> PC = alu_out (target from DECODE).
//  - Alu decoder (FUNCT):
//      funct3 000 -> sub if opcode[5] & funct7_5, else add
//      010 -> slt;  110 -> or;  111 -> and;  other -> add
//  - Latency in cycles, excluding extra mem_ready wait cycles:
//    lw 5, sw 4, R/I 4, jal 4, branch 3.
//  - mem_ready is ignored in states that do not access memory.
// STRUCTURE
//  - rvscc_ctrl_pkg: state_t enum, opcode localparams, alu_op_t,
//    result_src / alu_src / imm_src / alu_control encodings.
//    Extender and ALU import the same encodings.
//  - Sub-module alu_decoder (comb: alu_op, funct3, funct7_5, opcode[5] -> alu_control).
//  - This module: state register (async rst), next-state logic, output decode.
// TESTING
//  1. lw, mem_ready low 3 cycles in FETCH and 2 in MEM_READ
//     -> ir_write only on ready cycle; reg_write once in MEM_WB; 5+5 cycles total.
//  2. sw with mem_ready delayed 2 cycles
//     -> mem_write high exactly 3 cycles, adr_src=1, imm_src=1 in MEM_ADR, no reg_write.
//  3. R-type funct3=000, funct7_5=1 -> alu_control=001 in EXEC_R;
//     funct7_5=0 -> 000; addi with instr[30]=1 -> 000.
//  4. beq with zero=1 -> pc_write=1 in BRANCH; zero=0 -> 0;
//     bne (funct3=001) with zero=0 -> pc_write=1.
//  5. Opcode 1111111 -> illegal_instr 1-cycle pulse, return to FETCH,
//     no reg_write/mem_write.
//  6. rst asserted mid MEM_WRITE (async, between edges) -> mem_write drops at once;
//     after release FETCH with adr_src=0.

Source files
------------

// File: rtl/rvscc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path.
// The extender, ALU and controller all import these so select values stay consistent.
package rvscc_ctrl_pkg;

  // Controller states
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    JAL_ST    = 4'd9,
    BRANCH    = 4'd10
  } state_t;

  // Supported major opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Internal ALU operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'd0,
    ALU_OP_SUB   = 2'd1,
    ALU_OP_FUNCT = 2'd2
  } alu_op_t;

  // result mux
  localparam logic [1:0] RES_ALU_OUT    = 2'd0;
  localparam logic [1:0] RES_MEM_DATA   = 2'd1;
  localparam logic [1:0] RES_ALU_RESULT = 2'd2;

  // ALU operand A mux
  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
  localparam logic [1:0] SRC_A_RD1    = 2'd2;

  // ALU operand B mux
  localparam logic [1:0] SRC_B_RD2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  // ALU function
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate extender format
  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;
  localparam logic [1:0] IMM_J = 2'd3;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: turns the controller's coarse alu_op plus instruction fields
// into the concrete ALU function code.
module alu_decoder
  import rvscc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op_5,
  output logic [2:0] alu_control
);

  // Select ALU function; subtract only for R-type with instr[30] set (addi never subtracts)
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_SUB:   alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default:      alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core. Sequences the shared datapath
// one state per cycle and stalls on mem_ready in the memory-access states.
module multicycle_controller
  import rvscc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal_instr
);

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       illegal_raw;

  // State register; async reset returns to FETCH immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= FETCH;
    else     state_reg <= state_next;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_next    = state_reg;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    result_src    = RES_ALU_OUT;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RD2;
    imm_src       = IMM_I;
    alu_op        = ALU_OP_ADD;
    case (state_reg)
      FETCH: begin
        result_src   = RES_ALU_RESULT;
        alu_src_b    = SRC_B_FOUR;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        // Precompute OldPC + imm so a branch/jal target is waiting in alu_out
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        if (opcode == OP_BRANCH)   imm_src = IMM_B;
        else if (opcode == OP_JAL) imm_src = IMM_J;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = MEM_ADR;
          OP_R:              state_next = EXEC_R;
          OP_I_ALU:          state_next = EXEC_I;
          OP_JAL:            state_next = JAL_ST;
          OP_BRANCH:         state_next = BRANCH;
          default: begin
            illegal_raw = 1'b1;
            state_next  = FETCH;
          end
        endcase
      end
      MEM_ADR: begin
        alu_src_a  = SRC_A_RD1;
        alu_src_b  = SRC_B_IMM;
        imm_src    = opcode[5] ? IMM_S : IMM_I;
        state_next = opcode[5] ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = MEM_WB;
      end
      MEM_WB: begin
        result_src    = RES_MEM_DATA;
        reg_write_raw = 1'b1;
        state_next    = FETCH;
      end
      MEM_WRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      EXEC_R: begin
        alu_src_a  = SRC_A_RD1;
        alu_op     = ALU_OP_FUNCT;
        state_next = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a  = SRC_A_RD1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALU_OP_FUNCT;
        state_next = ALU_WB;
      end
      ALU_WB: begin
        reg_write_raw = 1'b1;
        state_next    = FETCH;
      end
      JAL_ST: begin
        // PC takes the target from alu_out while the ALU forms OldPC + 4 for rd
        alu_src_a  = SRC_A_OLD_PC;
        alu_src_b  = SRC_B_FOUR;
        pc_update  = 1'b1;
        imm_src    = IMM_J;
        state_next = ALU_WB;
      end
      BRANCH: begin
        alu_src_a  = SRC_A_RD1;
        alu_op     = ALU_OP_SUB;
        branch     = 1'b1;
        imm_src    = IMM_B;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .op_5        (opcode[5]),
    .alu_control (alu_control)
  );

  // Write strobes are gated by rst so a mid-access reset can never commit anything
  assign pc_write      = (pc_update | (branch & (zero ^ funct3[0]))) & ~rst;
  assign ir_write      = ir_write_raw & ~rst;
  assign mem_write     = mem_write_raw & ~rst;
  assign reg_write     = reg_write_raw & ~rst;
  assign illegal_instr = illegal_raw & ~rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus process drives one
// cycle of inputs and pushes the hand-derived control vector for that cycle;
// the monitor pops and compares on every falling edge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  typedef enum {S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
                S_EXEC_R, S_EXEC_I, S_ALU_WB, S_JAL, S_BRANCH} st_e;

  typedef struct {
    logic [16:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  multicycle_controller dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_control   (alu_control),
    .imm_src       (imm_src),
    .reg_write     (reg_write),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {pc_write, adr_src, mem_write, ir_write, result_src,
  // alu_src_a, alu_src_b, alu_control, imm_src, reg_write, illegal_instr}
  function automatic logic [16:0] expect_for(st_e st, logic rdy, logic r,
                                             logic [2:0] alu_e, logic [1:0] imm_e,
                                             logic taken, logic ill);
    logic pw = 0, ad = 0, mw = 0, iw = 0, rw = 0, il = 0;
    logic [1:0] rs = 0, a = 0, b = 0, im = 0;
    logic [2:0] al = 0;
    case (st)
      S_FETCH:     begin pw = rdy & ~r; iw = rdy & ~r; rs = 2; b = 2; end
      S_DECODE:    begin a = 1; b = 1; im = imm_e; il = ill; end
      S_MEM_ADR:   begin a = 2; b = 1; im = imm_e; end
      S_MEM_READ:  begin ad = 1; end
      S_MEM_WB:    begin rs = 1; rw = 1; end
      S_MEM_WRITE: begin ad = 1; mw = 1; end
      S_EXEC_R:    begin a = 2; b = 0; al = alu_e; end
      S_EXEC_I:    begin a = 2; b = 1; al = alu_e; end
      S_ALU_WB:    begin rw = 1; end
      S_JAL:       begin a = 1; b = 2; pw = 1; im = 3; end
      S_BRANCH:    begin a = 2; b = 0; al = 3'b001; pw = taken; im = 2; end
      default:     ;
    endcase
    return {pw, ad, mw, iw, rs, a, b, al, im, rw, il};
  endfunction

  // Drive one cycle of inputs, queue its expected outputs, advance to next posedge+1
  task automatic cyc(string tag, st_e st, logic [6:0] op, logic [2:0] f3, logic f75,
                     logic z, logic rdy, logic [2:0] alu_e = 3'b000,
                     logic [1:0] imm_e = 2'd0, logic taken = 1'b0, logic ill = 1'b0);
    exp_t e;
    opcode    = op;
    funct3    = f3;
    funct7_5  = f75;
    zero      = z;
    mem_ready = rdy;
    e.v   = expect_for(st, rdy, rst, alu_e, imm_e, taken, ill);
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every cycle that has a queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [16:0] got;
      mon_e = sb.pop_front();
      got = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
             alu_control, imm_src, reg_write, illegal_instr};
      n_vec++;
      if (got !== mon_e.v) begin
        n_miss++;
        $display("FAIL %s : got %b required %b", mon_e.tag, got, mon_e.v);
      end else begin
        $display("ok   %s : %b", mon_e.tag, got);
      end
    end
  end

  // ALU-class table: opcode, funct3, funct7_5, expected alu_control
  logic [6:0] at_op [7] = '{RT, RT, IT, RT, RT, IT, RT};
  logic [2:0] at_f3 [7] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b001};
  logic       at_f7 [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0] at_ex [7] = '{3'b001, 3'b000, 3'b000, 3'b101, 3'b011, 3'b010, 3'b000};

  // Branch table: funct3, zero, taken
  logic [2:0] bt_f3 [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
  logic       bt_z  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic       bt_tk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset state: FETCH selects, strobes gated even with mem_ready high
    cyc("reset_fetch", S_FETCH, LW, 3'b010, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    // lw with 3 FETCH and 2 MEM_READ wait cycles
    for (int i = 0; i < 3; i++) cyc("lw_fetch_wait", S_FETCH, LW, 3'b010, 1'b0, 1'b0, 1'b0);
    cyc("lw_fetch", S_FETCH, LW, 3'b010, 1'b0, 1'b0, 1'b1);
    cyc("lw_decode", S_DECODE, LW, 3'b010, 1'b0, 1'b0, 1'b0);
    cyc("lw_memadr", S_MEM_ADR, LW, 3'b010, 1'b0, 1'b0, 1'b1, 3'b000, 2'd0);
    for (int i = 0; i < 2; i++) cyc("lw_read_wait", S_MEM_READ, LW, 3'b010, 1'b0, 1'b0, 1'b0);
    cyc("lw_read", S_MEM_READ, LW, 3'b010, 1'b0, 1'b0, 1'b1);
    cyc("lw_wb", S_MEM_WB, LW, 3'b010, 1'b0, 1'b0, 1'b0);

    // sw with mem_ready delayed 2 cycles: mem_write high for 3 cycles
    cyc("sw_fetch", S_FETCH, SW, 3'b010, 1'b0, 1'b0, 1'b1);
    cyc("sw_decode", S_DECODE, SW, 3'b010, 1'b0, 1'b0, 1'b1);
    cyc("sw_memadr", S_MEM_ADR, SW, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 2'd1);
    cyc("sw_write_wait", S_MEM_WRITE, SW, 3'b010, 1'b0, 1'b0, 1'b0);
    cyc("sw_write_wait", S_MEM_WRITE, SW, 3'b010, 1'b0, 1'b0, 1'b0);
    cyc("sw_write", S_MEM_WRITE, SW, 3'b010, 1'b0, 1'b0, 1'b1);

    // R/I ALU decode cases (mem_ready high in non-memory states is ignored)
    for (int i = 0; i < 7; i++) begin
      cyc("alu_fetch", S_FETCH, at_op[i], at_f3[i], at_f7[i], 1'b1, 1'b1);
      cyc("alu_decode", S_DECODE, at_op[i], at_f3[i], at_f7[i], 1'b1, 1'b1);
      if (at_op[i] == RT)
        cyc("alu_exec_r", S_EXEC_R, at_op[i], at_f3[i], at_f7[i], 1'b1, 1'b1, at_ex[i]);
      else
        cyc("alu_exec_i", S_EXEC_I, at_op[i], at_f3[i], at_f7[i], 1'b1, 1'b1, at_ex[i]);
      cyc("alu_wb", S_ALU_WB, at_op[i], at_f3[i], at_f7[i], 1'b1, 1'b1);
    end

    // beq/bne taken/not-taken
    for (int i = 0; i < 4; i++) begin
      cyc("br_fetch", S_FETCH, BR, bt_f3[i], 1'b0, bt_z[i], 1'b1);
      cyc("br_decode", S_DECODE, BR, bt_f3[i], 1'b0, 1'b1, 1'b0, 3'b000, 2'd2);
      cyc("br_branch", S_BRANCH, BR, bt_f3[i], 1'b0, bt_z[i], 1'b1, 3'b000, 2'd0, bt_tk[i]);
    end

    // jal
    cyc("jal_fetch", S_FETCH, JL, 3'b000, 1'b0, 1'b0, 1'b1);
    cyc("jal_decode", S_DECODE, JL, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 2'd3);
    cyc("jal_jal", S_JAL, JL, 3'b000, 1'b0, 1'b0, 1'b0);
    cyc("jal_wb", S_ALU_WB, JL, 3'b000, 1'b0, 1'b0, 1'b0);

    // Illegal opcode: one-cycle pulse, back to FETCH
    cyc("ill_fetch", S_FETCH, BAD, 3'b000, 1'b0, 1'b0, 1'b1);
    cyc("ill_decode", S_DECODE, BAD, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 2'd0, 1'b0, 1'b1);
    cyc("ill_back", S_FETCH, BAD, 3'b000, 1'b0, 1'b0, 1'b0);

    // Async reset in the middle of a store
    cyc("rs_fetch", S_FETCH, SW, 3'b010, 1'b0, 1'b0, 1'b1);
    cyc("rs_decode", S_DECODE, SW, 3'b010, 1'b0, 1'b0, 1'b0);
    cyc("rs_memadr", S_MEM_ADR, SW, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 2'd1);
    cyc("rs_write_wait", S_MEM_WRITE, SW, 3'b010, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc("rs_in_reset", S_FETCH, SW, 3'b010, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    cyc("rs_after_idle", S_FETCH, SW, 3'b010, 1'b0, 1'b0, 1'b0);
    cyc("rs_after_fetch", S_FETCH, RT, 3'b000, 1'b0, 1'b0, 1'b1);
    cyc("rs_after_decode", S_DECODE, RT, 3'b000, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_miss++;
      $display("FAIL drain : got %0d pending required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog : got timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
